// File: rtl/serial_parity_frame_checker.sv
// Purpose : deserialises start / DATA_W data (LSB first) / odd-parity / stop frames,
//           flags parity and stop-bit errors, keeps a saturating error count.
// Latency : outputs update on the edge that samples the stop bit (no extra stage).
// Backpressure: none; bits are taken whenever i_rx_valid is high, gaps of any length hold state.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_rx_valid, i_rx_bit  serial bit strobe and line bit
//   i_clr_cnt             synchronous clear of o_err_cnt (wins over increment)
//   o_data                last completed data word
//   o_frame_valid         one-cycle completion pulse
//   o_parity_err          last frame failed odd parity (held)
//   o_frame_err           last frame stop bit was 0 (held)
//   o_busy                frame in progress
//   o_err_cnt             saturating count of errored frames
module serial_parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic              i_rx_bit,
    input  logic              i_clr_cnt,
    output logic [DATA_W-1:0] o_data,
    output logic              o_frame_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam int BCW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BCW-1:0]    bit_cnt;
    logic              acc;

    logic frame_done;
    logic frame_bad;

    // Completion is the valid edge in STOP; the error decision uses the
    // same values that are being registered into the status flags.
    always_comb begin
        frame_done = i_rx_valid && (state == STOP);
        frame_bad  = ~acc | ~i_rx_bit;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            acc           <= 1'b0;
            o_data        <= '0;
            o_frame_valid <= 1'b0;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_busy        <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            o_frame_valid <= 1'b0;

            if (i_rx_valid) begin
                case (state)
                    IDLE: begin
                        // A 1 on an idle line is just marking; only 0 starts a frame.
                        if (!i_rx_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            acc     <= 1'b0;
                            o_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        // Right shift: the first data bit ends up at bit 0.
                        shreg   <= {i_rx_bit, shreg[DATA_W-1:1]};
                        acc     <= acc ^ i_rx_bit;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        acc   <= acc ^ i_rx_bit;
                        state <= STOP;
                    end
                    STOP: begin
                        // A 0 stop bit still closes the frame; it is not a new start.
                        o_data        <= shreg;
                        o_parity_err  <= ~acc;
                        o_frame_err   <= ~i_rx_bit;
                        o_frame_valid <= 1'b1;
                        o_busy        <= 1'b0;
                        state         <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            if (i_clr_cnt) begin
                o_err_cnt <= '0;
            end else if (frame_done && frame_bad && (o_err_cnt != {CNT_W{1'b1}})) begin
                o_err_cnt <= o_err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_frame_checker.sv
module tb_serial_parity_frame_checker;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_valid = 1'b0;
    logic rx_bit = 1'b1;
    logic clr_cnt = 1'b0;

    logic [DW-1:0] a_data, b_data;
    logic          a_fv, a_perr, a_ferr, a_busy;
    logic          b_fv, b_perr, b_ferr, b_busy;
    logic [7:0]    a_cnt;
    logic [1:0]    b_cnt;

    always #5 clk = ~clk;

    // Default counter width.
    serial_parity_frame_checker #(.DATA_W(DW), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_bit(rx_bit),
        .i_clr_cnt(clr_cnt), .o_data(a_data), .o_frame_valid(a_fv),
        .o_parity_err(a_perr), .o_frame_err(a_ferr), .o_busy(a_busy),
        .o_err_cnt(a_cnt)
    );

    // Narrow counter so saturation is reachable quickly.
    serial_parity_frame_checker #(.DATA_W(DW), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_bit(rx_bit),
        .i_clr_cnt(clr_cnt), .o_data(b_data), .o_frame_valid(b_fv),
        .o_parity_err(b_perr), .o_frame_err(b_ferr), .o_busy(b_busy),
        .o_err_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (frame-level) ----------------
    bit            m_busy;
    bit            q[$];
    logic [DW-1:0] m_data;
    bit            m_perr, m_ferr, m_fv;
    int            m_cnt, m_cnt2;

    int vcount, busy_edges, last_pulse_v, prev_pulse_v;

    task automatic model_reset();
        m_busy = 0; q.delete(); m_data = '0;
        m_perr = 0; m_ferr = 0; m_fv = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit c);
        bit done, bad;
        done = 0; bad = 0; m_fv = 0;
        if (v) begin
            if (!m_busy) begin
                if (!b) begin m_busy = 1; q.delete(); end
            end else begin
                q.push_back(b);
                if (q.size() == DW + 2) begin
                    int ones;
                    ones = 0;
                    for (int i = 0; i < DW; i++) begin
                        m_data[i] = q[i];
                        ones += int'(q[i]);
                    end
                    ones += int'(q[DW]);
                    m_perr = (ones % 2 == 0);
                    m_ferr = (q[DW+1] == 1'b0);
                    m_fv   = 1; m_busy = 0; done = 1;
                    bad    = m_perr | m_ferr;
                end
            end
        end
        if (c) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (done && bad) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic compare_all();
        check("data_a", 32'(a_data), 32'(m_data));
        check("fv_a",   32'(a_fv),   32'(m_fv));
        check("perr_a", 32'(a_perr), 32'(m_perr));
        check("ferr_a", 32'(a_ferr), 32'(m_ferr));
        check("busy_a", 32'(a_busy), 32'(m_busy));
        check("cnt_a",  32'(a_cnt),  32'(m_cnt));
        check("data_b", 32'(b_data), 32'(m_data));
        check("fv_b",   32'(b_fv),   32'(m_fv));
        check("cnt_b",  32'(b_cnt),  32'(m_cnt2));
    endtask

    // Called at a negedge; applies inputs across one posedge, checks at the next negedge.
    task automatic edge_step(input bit v, input bit b, input bit c);
        rx_valid = v; rx_bit = b; clr_cnt = c;
        if (v) vcount++;
        if (v && a_busy) busy_edges++;
        @(posedge clk);
        model_edge(v, b, c);
        @(negedge clk);
        if (a_fv) begin prev_pulse_v = last_pulse_v; last_pulse_v = vcount; end
        compare_all();
        rx_valid = 0; clr_cnt = 0;
    endtask

    task automatic send_bit(input bit b, input int maxgap, input bit c);
        int g;
        g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        for (int i = 0; i < g; i++) edge_step(0, 1'($urandom), 0);
        edge_step(1, b, c);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit p, input bit s,
                              input int maxgap, input bit clr_last);
        send_bit(0, maxgap, 0);
        for (int i = 0; i < DW; i++) send_bit(d[i], maxgap, 0);
        send_bit(p, maxgap, 0);
        send_bit(s, maxgap, clr_last);
    endtask

    typedef struct {
        logic [DW-1:0] d;
        bit            p, s;
        int            gap, idle1;
        bit            clr_last, rst_before;
        logic [DW-1:0] ed;
        bit            ep, ef;
        int            ec, ec2;
    } vec_t;

    vec_t tbl[13];

    initial begin
        //            d      p  s  gap idle clr rstb  ed     ep ef ec ec2
        tbl[0]  = '{8'hA5, 1, 1, 0, 0, 0, 0, 8'hA5, 0, 0, 0, 0};
        tbl[1]  = '{8'h03, 1, 1, 0, 0, 0, 0, 8'h03, 0, 0, 0, 0};
        tbl[2]  = '{8'h03, 0, 1, 0, 0, 0, 0, 8'h03, 1, 0, 1, 1};
        tbl[3]  = '{8'h7E, 1, 0, 3, 3, 0, 0, 8'h7E, 0, 1, 2, 2};
        tbl[4]  = '{8'h5A, 1, 1, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0};
        tbl[5]  = '{8'h01, 1, 1, 0, 0, 0, 0, 8'h01, 1, 0, 1, 1};
        tbl[6]  = '{8'h01, 1, 1, 0, 0, 0, 0, 8'h01, 1, 0, 2, 2};
        tbl[7]  = '{8'h01, 1, 1, 0, 0, 0, 0, 8'h01, 1, 0, 3, 3};
        tbl[8]  = '{8'h01, 1, 1, 0, 0, 0, 0, 8'h01, 1, 0, 4, 3};
        tbl[9]  = '{8'h01, 1, 1, 0, 0, 0, 0, 8'h01, 1, 0, 5, 3};
        tbl[10] = '{8'h01, 1, 1, 0, 0, 1, 0, 8'h01, 1, 0, 0, 0};
        tbl[11] = '{8'hFF, 1, 1, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0};
        tbl[12] = '{8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};

        model_reset();
        vcount = 0; busy_edges = 0; last_pulse_v = 0; prev_pulse_v = 0;

        // Power-on reset.
        #2 rst = 1'b1;
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst_before) begin
                // Start bit plus four data bits, then reset between clock edges.
                edge_step(1, 0, 0);
                for (int k = 0; k < 4; k++) edge_step(1, tbl[i].d[k], 0);
                #2 rst = 1'b1;
                #1;
                check("rst_async_data", 32'(a_data), 32'h0);
                check("rst_async_busy", 32'(a_busy), 32'h0);
                check("rst_async_flags", {29'd0, a_fv, a_perr, a_ferr}, 32'h0);
                check("rst_async_cnt", 32'(a_cnt), 32'h0);
                model_reset();
                @(negedge clk);
                compare_all();
                rst = 1'b0;
            end
            for (int k = 0; k < tbl[i].idle1; k++) edge_step(1, 1, 0);
            if (i == 0) busy_edges = 0;
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, tbl[i].gap, tbl[i].clr_last);
            check($sformatf("vec%0d_pulse", i), 32'(a_fv), 32'h1);
            check($sformatf("vec%0d_data", i), 32'(a_data), 32'(tbl[i].ed));
            check($sformatf("vec%0d_perr", i), 32'(a_perr), 32'(tbl[i].ep));
            check($sformatf("vec%0d_ferr", i), 32'(a_ferr), 32'(tbl[i].ef));
            check($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].ec));
            check($sformatf("vec%0d_cnt2", i), 32'(b_cnt), 32'(tbl[i].ec2));
            if (i == 0) check("busy_valid_edges", 32'(busy_edges), 32'd10);
            if (i == 12) check("b2b_pulse_spacing", 32'(last_pulse_v - prev_pulse_v), 32'd11);
        end

        // Flags hold between completions.
        for (int k = 0; k < 5; k++) edge_step(0, 0, 0);
        check("hold_data", 32'(a_data), 32'h00);

        // Randomized frames against the model.
        for (int f = 0; f < 150; f++) begin
            logic [DW-1:0] d;
            bit p, s;
            int idl, gap;
            d   = DW'($urandom);
            p   = ~(^d);
            if ($urandom_range(0, 4) == 0) p = ~p;
            s   = ($urandom_range(0, 6) != 0);
            idl = $urandom_range(0, 2);
            gap = $urandom_range(0, 3);
            for (int k = 0; k < idl; k++) edge_step(1, 1, 0);
            edge_step(1, 0, 0);
            for (int k = 0; k < DW; k++) send_bit(d[k], gap, ($urandom_range(0, 29) == 0));
            send_bit(p, gap, 0);
            send_bit(s, gap, ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_parity_frame_checker.md
Name: serial_parity_frame_checker

Overview:
- Downstream receive-side consumer of the serial odd-parity generator.
- Deserialises a framed bit stream: start bit, DATA_W data bits LSB first, odd-parity bit, stop bit.
- Checks odd parity and stop-bit integrity, presents the parallel word with status flags, and keeps a saturating error count.
- Sits between the serial link and the parallel datapath.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..16).
- CNT_W, 8, width of saturating error counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_rx_valid  input  1  bit strobe; i_rx_bit sampled only on edges where this is 1.
- i_rx_bit  input  1  serial line bit.
- i_clr_cnt  input  1  synchronous clear of o_err_cnt.
- o_data  output  DATA_W  last received data word, LSB = first data bit received.
- o_frame_valid  output  1  one-cycle pulse: frame completed, o_data and flags updated.
- o_parity_err  output  1  last frame failed odd-parity check; held until next frame completes.
- o_frame_err  output  1  last frame stop bit was 0; held until next frame completes.
- o_busy  output  1  frame in progress (start bit accepted, stop bit not yet sampled).
- o_err_cnt  output  CNT_W  count of frames with any error, saturating.

Behaviour:
- Reset is asynchronous and active-high: i_rst=1 forces state IDLE immediately. All outputs, the shift register, the bit counter and the parity accumulator go to 0. Reset mid-frame discards the partial frame with no pulse.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on edges with i_rx_valid=1; with i_rx_valid=0 all state holds (gaps between bits of any length are legal).
- IDLE:
  - bit=0 → start accepted. Go to DATA, clear bit counter, clear parity accumulator, o_busy=1.
  - bit=1 → idle line, ignored.
- DATA:
  - Shift bit into the MSB of the shift register (right shift), so after DATA_W bits the first-received bit is at bit 0.
  - XOR bit into the accumulator.
  - After the DATA_W-th bit, go to PARITY.
- PARITY: XOR bit into the accumulator. Go to STOP.
- Odd parity: data ones plus parity bit must be odd, i.e. accumulator must equal 1. Accumulator = 0 means parity error.
- STOP: on the sampling edge, all of the following register simultaneously:
  - o_data ← shift register
  - o_parity_err ← ~accumulator
  - o_frame_err ← ~bit
  - o_frame_valid ← 1 for exactly one cycle
  - o_busy ← 0
  - state ← IDLE
- A stop bit of 0 still completes the frame. The checker does not treat it as a new start bit; the next valid 0 in IDLE starts the next frame.
- o_data, o_parity_err and o_frame_err hold their values between completions.
- o_frame_valid is 0 on every cycle other than the completion edge.
- Latency: outputs valid in the cycle immediately after the edge that samples the stop bit. There is no additional pipeline stage.
- Error counter:
  - Increments by 1 on a completion edge where parity_err | frame_err.
  - Saturates at 2^CNT_W-1 (no wrap).
  - i_clr_cnt=1 sets it to 0. Clear beats a simultaneous increment.
- Back-to-back frames: a start bit sampled on the very next valid edge after the stop bit is accepted normally.

Test Plan:
- DATA_W=8, good frame, 0xA5 (bits LSB-first 1,0,1,0,0,1,0,1; 4 ones → parity bit 1):
  - Stimulus: 0, data bits, 1, 1 with contiguous valids.
  - Response: o_frame_valid pulses once, o_data=0xA5, o_parity_err=0, o_frame_err=0, o_err_cnt=0, o_busy high for exactly 10 valid edges.
- Parity error: 0x03 sent with parity bit 1 (2 ones, correct bit is 1), then 0x03 with parity bit 0 → first frame clean; second frame o_parity_err=1, o_err_cnt=1.
- Framing error and gaps: 0x7E with correct parity 1 and stop bit 0, i_rx_valid toggled with random 0–3 idle cycles between bits → o_data=0x7E, o_frame_err=1, o_parity_err=0, o_err_cnt increments by 1. Idle 1s before the start bit are ignored.
- Reset mid-frame: assert i_rst asynchronously (between clock edges) after 4 data bits → outputs 0 immediately, no pulse. A following clean frame 0x5A decodes correctly.
- Saturation and clear (CNT_W=2):
  - Five bad-parity frames → o_err_cnt reads 1,2,3,3,3.
  - A sixth bad frame with i_clr_cnt=1 on its completion edge → o_err_cnt=0.
- Back-to-back: two clean frames 0xFF (parity bit 1) and 0x00 (parity bit 1) with no gap → two pulses separated by exactly 11 valid edges, o_data 0xFF then 0x00, no errors.
